// File: rtl/qspi_sram_responder_pkg.sv
// Shared definitions for the serial SRAM responder: the command opcodes and
// phase lengths understood on the wire, and the protocol state encoding.
package qspi_sram_responder_pkg;

    localparam logic [7:0] CMD_READ  = 8'h03;
    localparam logic [7:0] CMD_WRITE = 8'h02;
    localparam logic [7:0] CMD_EQIO  = 8'h38;
    localparam logic [7:0] CMD_RSTIO = 8'hFF;

    localparam int unsigned ADDR_NIBBLES  = 6;
    localparam int unsigned DUMMY_NIBBLES = 2;
    localparam int unsigned CMD_NIBBLES   = 2;
    localparam int unsigned SPI_CMD_BITS  = 8;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CMD,
        ST_ADDR,
        ST_DUMMY,
        ST_RDATA,
        ST_WDATA,
        ST_IGNORE
    } state_t;

    // Commands that carry an address phase and a data phase.
    function automatic logic is_access(input logic [7:0] cmd);
        return (cmd == CMD_READ) || (cmd == CMD_WRITE);
    endfunction

endpackage

// File: rtl/qspi_sram_responder_if.sv
// SRAM pin group between an SPI/SQI initiator and the responder.
//   sram_cs_n, sram_sck, sram_sio*_i : driven by the initiator
//   sram_sio*_o, sram_sio_oe         : driven by the responder
interface qspi_sram_responder_if;

    logic sram_cs_n;
    logic sram_sck;
    logic sram_sio0_i;
    logic sram_sio1_i;
    logic sram_sio2_i;
    logic sram_sio3_i;
    logic sram_sio0_o;
    logic sram_sio1_o;
    logic sram_sio2_o;
    logic sram_sio3_o;
    logic sram_sio_oe;

    modport master (
        output sram_cs_n, sram_sck,
        output sram_sio0_i, sram_sio1_i, sram_sio2_i, sram_sio3_i,
        input  sram_sio0_o, sram_sio1_o, sram_sio2_o, sram_sio3_o,
        input  sram_sio_oe
    );

    modport slave (
        input  sram_cs_n, sram_sck,
        input  sram_sio0_i, sram_sio1_i, sram_sio2_i, sram_sio3_i,
        output sram_sio0_o, sram_sio1_o, sram_sio2_o, sram_sio3_o,
        output sram_sio_oe
    );

endinterface

// File: rtl/qspi_pin_sync.sv
// 2-FF synchronizers for the SRAM pins plus edge strobes for sck and cs_n.
//   clk, reset_n         : system clock, async active-low reset
//   cs_n, sck, sio[3:0]  : raw pins
//   sio_s                : synchronized SIO, same latency as the sck strobes
//   sck_rise_c/fall_c    : one-cycle strobes on synchronized sck edges
//   cs_rise_c/fall_c     : one-cycle strobes on synchronized cs_n edges
module qspi_pin_sync (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       cs_n,
    input  logic       sck,
    input  logic [3:0] sio,
    output logic [3:0] sio_s,
    output logic       sck_rise_c,
    output logic       sck_fall_c,
    output logic       cs_rise_c,
    output logic       cs_fall_c
);

    // [0] metastable stage, [1] synchronized, [2] previous synchronized value
    logic [2:0] cs_sh;
    logic [2:0] sck_sh;
    logic [3:0] sio_m;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cs_sh  <= '1;
            sck_sh <= '0;
            sio_m  <= '0;
            sio_s  <= '0;
        end else begin
            cs_sh  <= {cs_sh[1:0], cs_n};
            sck_sh <= {sck_sh[1:0], sck};
            sio_m  <= sio;
            sio_s  <= sio_m;
        end
    end

    assign sck_rise_c =  sck_sh[1] & ~sck_sh[2];
    assign sck_fall_c = ~sck_sh[1] &  sck_sh[2];
    assign cs_rise_c  =  cs_sh[1]  & ~cs_sh[2];
    assign cs_fall_c  = ~cs_sh[1]  &  cs_sh[2];

endmodule

// File: rtl/qspi_sram_responder.sv
// Target-side serial SRAM model: decodes EQIO/RSTIO/quad READ/quad WRITE and
// serves bursts from an internal word array with a backdoor port.
//   clk, reset_n          : system clock (>= 4x sck), async active-low reset
//   bus (slave)           : SRAM pin group
//   quad_mode             : SQI mode active
//   bd_we/bd_addr/bd_wdata: backdoor write
//   bd_rdata              : array word at bd_addr, one cycle latency
module qspi_sram_responder
    import qspi_sram_responder_pkg::*;
#(
    parameter int unsigned WORD_WIDTH        = 16,
    parameter int unsigned MEM_ADDRESS_WIDTH = 8
) (
    input  logic                         clk,
    input  logic                         reset_n,
    qspi_sram_responder_if.slave         bus,
    output logic                         quad_mode,
    input  logic                         bd_we,
    input  logic [MEM_ADDRESS_WIDTH-1:0] bd_addr,
    input  logic [WORD_WIDTH-1:0]        bd_wdata,
    output logic [WORD_WIDTH-1:0]        bd_rdata
);

    localparam int unsigned NIB    = WORD_WIDTH / 4;
    localparam int unsigned DEPTH  = 2 ** MEM_ADDRESS_WIDTH;
    localparam int unsigned CNT_W  = $clog2(NIB + SPI_CMD_BITS);
    localparam int unsigned AKEEP  = MEM_ADDRESS_WIDTH + 1;

    logic [3:0] sio_s;
    logic       sck_rise_c, sck_fall_c, cs_rise_c, cs_fall_c;

    qspi_pin_sync u_sync (
        .clk        (clk),
        .reset_n    (reset_n),
        .cs_n       (bus.sram_cs_n),
        .sck        (bus.sram_sck),
        .sio        ({bus.sram_sio3_i, bus.sram_sio2_i, bus.sram_sio1_i, bus.sram_sio0_i}),
        .sio_s      (sio_s),
        .sck_rise_c (sck_rise_c),
        .sck_fall_c (sck_fall_c),
        .cs_rise_c  (cs_rise_c),
        .cs_fall_c  (cs_fall_c)
    );

    state_t                       state_q, state_d;
    logic [CNT_W-1:0]             cnt_q, cnt_d;
    logic [7:0]                   cmd_q, cmd_d;
    logic [AKEEP-1:0]             ash_q, ash_d;
    logic [MEM_ADDRESS_WIDTH-1:0] addr_q, addr_d;
    logic [WORD_WIDTH-1:0]        dsh_q, dsh_d;
    logic [3:0]                   sio_q, sio_d;
    logic                         oe_q, oe_d;
    logic                         quad_q, quad_d;

    logic [WORD_WIDTH-1:0]        mem [DEPTH];
    logic                         mem_we_c;
    logic [WORD_WIDTH-1:0]        wdata_c;
    logic [MEM_ADDRESS_WIDTH-1:0] addr_inc_c;

    assign addr_inc_c = addr_q + MEM_ADDRESS_WIDTH'(1);
    assign wdata_c    = WORD_WIDTH'({dsh_q, sio_s});

    // State register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            cmd_q   <= '0;
            ash_q   <= '0;
            addr_q  <= '0;
            dsh_q   <= '0;
            sio_q   <= '0;
            oe_q    <= 1'b0;
            quad_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            cmd_q   <= cmd_d;
            ash_q   <= ash_d;
            addr_q  <= addr_d;
            dsh_q   <= dsh_d;
            sio_q   <= sio_d;
            oe_q    <= oe_d;
            quad_q  <= quad_d;
        end
    end

    // Protocol decode; cs_n rise preempts any sck edge seen in the same cycle
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        cmd_d    = cmd_q;
        ash_d    = ash_q;
        addr_d   = addr_q;
        dsh_d    = dsh_q;
        sio_d    = sio_q;
        oe_d     = oe_q;
        quad_d   = quad_q;
        mem_we_c = 1'b0;

        if (cs_rise_c) begin
            state_d = ST_IDLE;
            oe_d    = 1'b0;
            sio_d   = '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (cs_fall_c) begin
                        state_d = ST_CMD;
                        cnt_d   = '0;
                    end
                end
                ST_CMD: begin
                    if (sck_rise_c) begin
                        cnt_d = cnt_q + CNT_W'(1);
                        if (quad_q) begin
                            cmd_d = {cmd_q[3:0], sio_s};
                            if (cnt_q == CNT_W'(CMD_NIBBLES - 1)) begin
                                cnt_d = '0;
                                if (is_access(cmd_d)) begin
                                    state_d = ST_ADDR;
                                end else begin
                                    state_d = ST_IGNORE;
                                    if (cmd_d == CMD_RSTIO) quad_d = 1'b0;
                                end
                            end
                        end else begin
                            // Single-line mode only understands EQIO
                            cmd_d = {cmd_q[6:0], sio_s[0]};
                            if (cnt_q == CNT_W'(SPI_CMD_BITS - 1)) begin
                                state_d = ST_IGNORE;
                                if (cmd_d == CMD_EQIO) quad_d = 1'b1;
                            end
                        end
                    end
                end
                ST_ADDR: begin
                    if (sck_rise_c) begin
                        // Only the byte-address bits that select a word are kept
                        ash_d = AKEEP'({ash_q, sio_s});
                        cnt_d = cnt_q + CNT_W'(1);
                        if (cnt_q == CNT_W'(ADDR_NIBBLES - 1)) begin
                            cnt_d   = '0;
                            addr_d  = MEM_ADDRESS_WIDTH'(ash_d >> 1);
                            state_d = (cmd_q == CMD_READ) ? ST_DUMMY : ST_WDATA;
                        end
                    end
                end
                ST_DUMMY: begin
                    if (sck_rise_c) begin
                        cnt_d = cnt_q + CNT_W'(1);
                        if (cnt_q == CNT_W'(DUMMY_NIBBLES - 1)) begin
                            cnt_d   = '0;
                            dsh_d   = mem[addr_q];
                            state_d = ST_RDATA;
                        end
                    end
                end
                ST_RDATA: begin
                    if (sck_fall_c) begin
                        oe_d  = 1'b1;
                        sio_d = dsh_q[WORD_WIDTH-1 -: 4];
                        dsh_d = WORD_WIDTH'({dsh_q, 4'b0000});
                        cnt_d = cnt_q + CNT_W'(1);
                    end else if (sck_rise_c && (cnt_q == CNT_W'(NIB))) begin
                        // Prefetch on the last nibble's rise, ready for the next fall
                        addr_d = addr_inc_c;
                        dsh_d  = mem[addr_inc_c];
                        cnt_d  = '0;
                    end
                end
                ST_WDATA: begin
                    if (sck_rise_c) begin
                        dsh_d = wdata_c;
                        cnt_d = cnt_q + CNT_W'(1);
                        if (cnt_q == CNT_W'(NIB - 1)) begin
                            mem_we_c = 1'b1;
                            addr_d   = addr_inc_c;
                            cnt_d    = '0;
                        end
                    end
                end
                ST_IGNORE: begin
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    // Word array; a bus write takes the port over a same-cycle backdoor write
    always_ff @(posedge clk) begin
        if (mem_we_c) begin
            mem[addr_q] <= wdata_c;
        end else if (bd_we) begin
            mem[bd_addr] <= bd_wdata;
        end
    end

    // Backdoor readback
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            bd_rdata <= '0;
        end else begin
            bd_rdata <= mem[bd_addr];
        end
    end

    assign bus.sram_sio0_o = sio_q[0];
    assign bus.sram_sio1_o = sio_q[1];
    assign bus.sram_sio2_o = sio_q[2];
    assign bus.sram_sio3_o = sio_q[3];
    assign bus.sram_sio_oe = oe_q;
    assign quad_mode       = quad_q;

endmodule

// File: tb/tb_qspi_sram_responder.sv
// Self-checking bench for qspi_sram_responder: acts as the SPI/SQI initiator,
// keeps a word-array reference model and checks reads, writes and backdoor.
module tb_qspi_sram_responder;

    localparam int unsigned WW    = 16;
    localparam int unsigned AW    = 8;
    localparam int unsigned DEPTH = 256;
    localparam time         HALF  = 60;

    logic          clk;
    logic          reset_n;
    logic          quad_mode;
    logic          bd_we;
    logic [AW-1:0] bd_addr;
    logic [WW-1:0] bd_wdata;
    logic [WW-1:0] bd_rdata;

    qspi_sram_responder_if bus ();

    qspi_sram_responder #(
        .WORD_WIDTH        (WW),
        .MEM_ADDRESS_WIDTH (AW)
    ) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .bus       (bus),
        .quad_mode (quad_mode),
        .bd_we     (bd_we),
        .bd_addr   (bd_addr),
        .bd_wdata  (bd_wdata),
        .bd_rdata  (bd_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int            tests_run;
    int            tests_failed;
    logic [WW-1:0] model [DEPTH];
    logic [WW-1:0] wbuf  [8];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests_run++;
        assert (obs === exp) else begin
            tests_failed++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [3:0] sio_out();
        return {bus.sram_sio3_o, bus.sram_sio2_o, bus.sram_sio1_o, bus.sram_sio0_o};
    endfunction

    // Byte address -> word index, wrapping over the array depth
    function automatic int widx(input logic [23:0] a, input int k);
        return ((int'(a) / 2) + k) % DEPTH;
    endfunction

    task automatic set_sio(input logic [3:0] n);
        {bus.sram_sio3_i, bus.sram_sio2_i, bus.sram_sio1_i, bus.sram_sio0_i} = n;
    endtask

    task automatic nib(input logic [3:0] n);
        set_sio(n);
        #HALF bus.sram_sck = 1'b1;
        #HALF bus.sram_sck = 1'b0;
    endtask

    // Sample {oe, sio} late in the low phase, then clock
    task automatic rd_nib(output logic [4:0] v);
        #HALF v = {bus.sram_sio_oe, sio_out()};
        bus.sram_sck = 1'b1;
        #HALF bus.sram_sck = 1'b0;
    endtask

    task automatic cs_begin();
        bus.sram_cs_n = 1'b0;
        #HALF;
    endtask

    task automatic cs_end();
        #HALF bus.sram_cs_n = 1'b1;
        #30 check("cs_rise_release", 32'({bus.sram_sio_oe, sio_out()}), 32'd0);
        #(3*HALF);
    endtask

    task automatic q_cmd(input logic [7:0] c);
        nib(c[7:4]);
        nib(c[3:0]);
    endtask

    task automatic q_addr(input logic [23:0] a);
        for (int i = 5; i >= 0; i--) nib(a[4*i +: 4]);
    endtask

    task automatic spi_byte(input logic [7:0] b);
        for (int i = 7; i >= 0; i--) nib({3'($urandom), b[i]});
    endtask

    task automatic q_write(input logic [23:0] a, input int n);
        logic [WW-1:0] d;
        cs_begin();
        q_cmd(8'h02);
        q_addr(a);
        for (int w = 0; w < n; w++) begin
            d = wbuf[w];
            for (int k = 3; k >= 0; k--) nib(d[4*k +: 4]);
            model[widx(a, w)] = d;
        end
        cs_end();
    endtask

    task automatic q_read(input logic [23:0] a, input int n, input string tag);
        logic [4:0]    v;
        logic [WW-1:0] e;
        cs_begin();
        q_cmd(8'h03);
        q_addr(a);
        nib(4'($urandom));
        nib(4'($urandom));
        for (int w = 0; w < n; w++) begin
            e = model[widx(a, w)];
            for (int k = 3; k >= 0; k--) begin
                rd_nib(v);
                check(tag, 32'(v), 32'({1'b1, e[4*k +: 4]}));
            end
        end
        cs_end();
    endtask

    task automatic bd_write(input logic [AW-1:0] a, input logic [WW-1:0] d);
        bd_addr  = a;
        bd_wdata = d;
        bd_we    = 1'b1;
        #10 bd_we = 1'b0;
    endtask

    task automatic bd_check(input logic [AW-1:0] a, input string tag);
        bd_addr = a;
        #20 check(tag, 32'(bd_rdata), 32'(model[a]));
    endtask

    initial begin
        logic [4:0]  v;
        logic        oe_seen;
        logic [23:0] a;
        int          n;

        tests_run     = 0;
        tests_failed  = 0;
        reset_n       = 1'b0;
        bd_we         = 1'b0;
        bd_addr       = '0;
        bd_wdata      = '0;
        bus.sram_cs_n = 1'b1;
        bus.sram_sck  = 1'b0;
        set_sio(4'h0);

        // Pins wiggle while reset is held
        for (int i = 0; i < 8; i++) begin
            #20 bus.sram_sck = ~bus.sram_sck;
            set_sio(4'($urandom));
            bus.sram_cs_n = (i % 3) == 0;
        end
        check("rst_oe",     32'(bus.sram_sio_oe), 32'd0);
        check("rst_sio",    32'(sio_out()),       32'd0);
        check("rst_quad",   32'(quad_mode),       32'd0);
        check("rst_bdread", 32'(bd_rdata),        32'd0);
        bus.sram_cs_n = 1'b1;
        bus.sram_sck  = 1'b0;
        #40 reset_n = 1'b1;
        #50;

        // Preload the whole array through the backdoor
        for (int i = 0; i < DEPTH; i++) begin
            model[i] = 16'($urandom);
            if (i == 5) model[i] = 16'hAAAA;
            bd_write(8'(i), model[i]);
        end
        for (int i = 0; i < 4; i++) bd_check(8'($urandom), "bd_spot");

        // A non-EQIO command in single-line mode is ignored
        cs_begin();
        spi_byte(8'h03);
        q_addr(24'($urandom));
        cs_end();
        check("spi_other_quad", 32'(quad_mode), 32'd0);

        // EQIO
        cs_begin();
        spi_byte(8'h38);
        cs_end();
        check("eqio_quad", 32'(quad_mode), 32'd1);

        // Quad write and read at byte 0x10 (word 8)
        wbuf[0] = 16'h1234;
        q_write(24'h000010, 1);
        bd_addr = 8'd8;
        #20 check("wr_word8", 32'(bd_rdata), 32'h1234);
        q_read(24'h000010, 1, "rd_word8");

        // Burst across the top of the array
        for (int i = 0; i < 3; i++) wbuf[i] = 16'($urandom);
        q_write(24'h0001FE, 3);
        bd_check(8'd255, "wrap_w255");
        bd_check(8'd0,   "wrap_w0");
        bd_check(8'd1,   "wrap_w1");
        q_read(24'h0001FE, 3, "rd_wrap");

        // Random bursts, upper address bits and bit 0 are don't-care
        for (int t = 0; t < 8; t++) begin
            a = 24'($urandom);
            n = $urandom_range(1, 4);
            if ($urandom_range(0, 1) == 1) begin
                for (int i = 0; i < n; i++) wbuf[i] = 16'($urandom);
                q_write(a, n);
            end else begin
                q_read(a, n, "rd_rand");
            end
        end

        // Aborted write leaves the word untouched
        model[5] = 16'hAAAA;
        bd_write(8'd5, 16'hAAAA);
        cs_begin();
        q_cmd(8'h02);
        q_addr(24'h00000A);
        nib(4'hB);
        nib(4'hE);
        cs_end();
        bd_check(8'd5, "abort_wr");

        // Aborted read releases the lines
        cs_begin();
        q_cmd(8'h03);
        q_addr(24'h00000A);
        nib(4'h0);
        nib(4'h0);
        rd_nib(v);
        check("abort_rd_n0", 32'(v), 32'h1A);
        rd_nib(v);
        check("abort_rd_n1", 32'(v), 32'h1A);
        cs_end();

        // Unknown quad command
        oe_seen = 1'b0;
        cs_begin();
        q_cmd(8'h9F);
        for (int i = 0; i < 8; i++) begin
            set_sio(4'($urandom));
            rd_nib(v);
            oe_seen |= v[4];
        end
        check("unknown_oe", 32'(oe_seen), 32'd0);
        cs_end();

        // Bus write and backdoor write to word 3 in the same clk
        cs_begin();
        q_cmd(8'h02);
        q_addr(24'h000006);
        nib(4'h2);
        nib(4'h2);
        nib(4'h2);
        set_sio(4'h2);
        #HALF bus.sram_sck = 1'b1;
        #20;
        bd_addr  = 8'd3;
        bd_wdata = 16'h1111;
        bd_we    = 1'b1;
        #10 bd_we = 1'b0;
        #(HALF - 30) bus.sram_sck = 1'b0;
        cs_end();
        model[3] = 16'h2222;
        bd_check(8'd3, "collision");

        // RSTIO, then a quad read is not understood
        cs_begin();
        q_cmd(8'hFF);
        cs_end();
        check("rstio_quad", 32'(quad_mode), 32'd0);
        oe_seen = 1'b0;
        cs_begin();
        q_cmd(8'h03);
        q_addr(24'h000010);
        nib(4'h0);
        nib(4'h0);
        for (int i = 0; i < 4; i++) begin
            rd_nib(v);
            oe_seen |= v[4];
        end
        check("rstio_rd_oe", 32'(oe_seen), 32'd0);
        cs_end();
        check("rstio_quad_hold", 32'(quad_mode), 32'd0);

        // Back to SQI, full array comparison
        cs_begin();
        spi_byte(8'h38);
        cs_end();
        check("eqio2_quad", 32'(quad_mode), 32'd1);
        for (int i = 0; i < DEPTH; i++) bd_check(8'(i), "sweep");

        // Reset in the middle of a read
        cs_begin();
        q_cmd(8'h03);
        q_addr(24'h000010);
        nib(4'h0);
        nib(4'h0);
        rd_nib(v);
        check("midrst_n0", 32'(v), 32'({1'b1, model[8][15:12]}));
        #HALF reset_n = 1'b0;
        #10 check("midrst_outs", 32'({bus.sram_sio_oe, sio_out(), quad_mode, bd_rdata}), 32'd0);
        bus.sram_cs_n = 1'b1;
        bus.sram_sck  = 1'b0;
        #40 reset_n = 1'b1;
        #50 check("midrst_quad", 32'(quad_mode), 32'd0);
        bd_check(8'd8, "midrst_array");

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
